// File: rtl/move_sequencer.sv
// move_sequencer: queues user moves in a small FIFO and issues them one at a time
// to the game FSM, waiting for each round to finish (or the watchdog) before the next.
module move_sequencer #(
   parameter int DEPTH    = 4,
   parameter int WD_LIMIT = 64
) (
   input  logic                      in_clka,
   input  logic                      in_restart,
   input  logic                      in_data_in,
   input  logic [4:0]                in_data,
   input  logic [24:0]               in_cleared,
   input  logic                      in_display_done,
   input  logic                      in_gameover,
   input  logic                      in_win,
   output logic                      out_data_in,
   output logic [4:0]                out_data,
   output logic [$clog2(DEPTH):0]    out_count,
   output logic                      out_full,
   output logic                      out_empty,
   output logic                      out_reject,
   output logic                      out_drop,
   output logic                      out_timeout,
   output logic [7:0]                out_moves,
   output logic [1:0]                out_state
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(WD_LIMIT + 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] HALT  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [WW-1:0] wd_q, wd_d;
   logic [4:0]    data_q, data_d;
   logic [7:0]    moves_q, moves_d;
   logic          issue_q, issue_d, reject_q, reject_d, drop_q, drop_d;
   logic          timeout_q, timeout_d, full_q, full_d, empty_q, empty_d;
   logic [4:0]    mem_q [DEPTH];
   logic [4:0]    head;
   logic          pop, push, stop;

   assign head = mem_q[rd_ptr_q];
   assign pop  = state_q == ISSUE;
   assign stop = in_gameover | in_win;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push = in_data_in && in_data <= 5'd24 && state_q != HALT && (!full_q || pop);

   always_comb begin
      state_d   = state_q;
      wd_d      = wd_q;
      data_d    = data_q;
      moves_d   = moves_q;
      issue_d   = 1'b0;
      drop_d    = 1'b0;
      timeout_d = 1'b0;
      reject_d  = in_data_in && !push;
      case (state_q)
         IDLE: state_d = stop ? HALT : (count_q != '0) ? ISSUE : IDLE;
         ISSUE: begin
            if (in_cleared[head]) begin
               drop_d  = 1'b1;
               state_d = IDLE;
            end else begin
               data_d  = head;
               issue_d = 1'b1;
               moves_d = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
               wd_d    = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (stop) state_d = HALT;
            else if (in_display_done) state_d = IDLE;
            else if (wd_q == WW'(WD_LIMIT - 1)) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else wd_d = wd_q + WW'(1);
         end
         default: state_d = HALT;
      endcase
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      if (state_d == HALT) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
      full_d  = count_d == CW'(DEPTH);
      empty_d = count_d == '0;
   end

   always_ff @(posedge in_clka or posedge in_restart) begin
      if (in_restart) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         wd_q      <= '0;
         data_q    <= '0;
         moves_q   <= '0;
         issue_q   <= 1'b0;
         reject_q  <= 1'b0;
         drop_q    <= 1'b0;
         timeout_q <= 1'b0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         wd_q      <= wd_d;
         data_q    <= data_d;
         moves_q   <= moves_d;
         issue_q   <= issue_d;
         reject_q  <= reject_d;
         drop_q    <= drop_d;
         timeout_q <= timeout_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
      end
   end

   always_ff @(posedge in_clka) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   assign out_data_in = issue_q;
   assign out_data    = data_q;
   assign out_count   = count_q;
   assign out_full    = full_q;
   assign out_empty   = empty_q;
   assign out_reject  = reject_q;
   assign out_drop    = drop_q;
   assign out_timeout = timeout_q;
   assign out_moves   = moves_q;
   assign out_state   = state_q;
endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: move FIFO depth (power of 2, at least 2).
REQ-002 Parameter WD_LIMIT, default 64: watchdog limit, in cycles, for state WAIT.
REQ-003 in_clka  input  1  sole clock; all state updates on the rising edge.
REQ-004 in_restart  input  1  reset, asynchronous and active-high.
REQ-005 in_data_in  input  1  user move strobe, sampled each cycle.
REQ-006 in_data  input  5  cell index of the user move, valid 0..24.
REQ-007 in_cleared  input  25  cleared-cell mask from the datapath; bit i set means cell i is already revealed.
REQ-008 in_display_done  input  1  pulse from the game FSM marking the end of a round.
REQ-009 in_gameover  input  1  game lost (level).
REQ-010 in_win  input  1  game won (level).
REQ-011 out_data_in  output  1  one-cycle issue strobe to the game FSM.
REQ-012 out_data  output  5  issued cell index; holds its value until the next issue.
REQ-013 out_count  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-014 out_full / out_empty  output  1 each  FIFO status flags.
REQ-015 out_reject  output  1  one-cycle pulse when an incoming move is refused.
REQ-016 out_drop  output  1  one-cycle pulse when a queued move is discarded because its cell is already cleared.
REQ-017 out_timeout  output  1  one-cycle pulse when the watchdog expires.
REQ-018 out_moves  output  8  count of issued moves; saturates at 255.
REQ-019 out_state  output  2  FSM state: IDLE=0, ISSUE=1, WAIT=2, HALT=3.

Function
REQ-020 The block SHALL accept a move (push) when in_data_in=1, in_data<=24, state!=HALT, and the FIFO is not full; a push in the same cycle as a pop SHALL also be accepted when the FIFO is full.
REQ-021 When in_data_in=1 and a move is not accepted (out of range, full without a simultaneous pop, or HALT), the block SHALL drive out_reject=1 for the next cycle and leave the FIFO unchanged.
REQ-022 The FIFO SHALL be first-in first-out; pointers SHALL wrap modulo DEPTH; out_count SHALL equal pushes minus pops.
REQ-023 In IDLE, in_gameover or in_win SHALL move the FSM to HALT; otherwise a non-empty FIFO SHALL move it to ISSUE; otherwise it SHALL stay in IDLE.
REQ-024 ISSUE SHALL last exactly one cycle and pop the FIFO head.
REQ-025 In ISSUE, if in_cleared[head]=1, the block SHALL pulse out_drop, suppress the issue strobe, leave out_moves unchanged, and return to IDLE.
REQ-026 In ISSUE, if in_cleared[head]=0, the block SHALL register out_data=head, pulse out_data_in for one cycle, increment out_moves (saturating at 255), and go to WAIT.
REQ-027 Issue latency SHALL be: a push into an empty FIFO while in IDLE produces out_data_in exactly 2 cycles after the push edge.
REQ-028 In WAIT, in_gameover or in_win SHALL move the FSM to HALT, taking priority over in_display_done.
REQ-029 In WAIT, in_display_done=1 SHALL move the FSM to IDLE.
REQ-030 The watchdog SHALL count cycles spent in WAIT; on reaching WD_LIMIT without in_display_done, the block SHALL pulse out_timeout and return to IDLE.
REQ-031 The watchdog SHALL clear on every entry to WAIT.
REQ-032 On entry to HALT the FIFO SHALL be flushed (out_count=0).
REQ-033 HALT SHALL be left only by reset.
REQ-034 At most one out_data_in pulse SHALL be outstanding at any time.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 While in_restart=1, and asynchronously on its assertion: state=IDLE, FIFO empty, out_count=0, out_empty=1, out_full=0, out_data=0, out_data_in=0, out_reject=0, out_drop=0, out_timeout=0, out_moves=0, watchdog=0.
REQ-037 Reset asserted mid-operation (including WAIT and HALT) SHALL discard queued moves and the in-flight handshake.
REQ-038 No pulse output SHALL fire in the first cycle after reset deasserts.

Verification
REQ-039 Push 2 in IDLE with in_cleared=0 -> out_data_in=1 with out_data=2 two cycles later, then state=WAIT; in_display_done -> IDLE; out_moves=1.
REQ-040 Push 2, 5, 7, 9, 11 back-to-back while WAIT is held -> first four accepted (out_full=1), 11 rejected; after completion, issue order is 5, 7, 9 after 2.
REQ-041 Push 25 -> out_reject pulse, out_count unchanged; push 5 with in_cleared[5]=1 -> out_drop pulse, no out_data_in, out_moves unchanged.
REQ-042 Assert in_gameover during WAIT with 3 moves queued -> HALT, out_count=0; subsequent pushes rejected; only in_restart returns to IDLE.
REQ-043 Hold in WAIT without done for 64 cycles -> out_timeout pulse, IDLE, next queued move issued.
REQ-044 Assert in_restart asynchronously mid-WAIT with 2 queued moves -> all outputs at reset values immediately; 300 issued moves -> out_moves=255.
